// File: rtl/imem_loader.sv
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot loader that fills instruction memory from a little-endian
//             byte stream, holds the CPU in reset while loading, then releases
//             it. Optional checksum trailer: IMEM_LOADER_CHECKSUM_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   num_instructions
);

    localparam int          c_bytes = DATA_WIDTH / 8;
    localparam int          c_bcw   = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam logic [63:0] c_depth = 64'd1 << ADDR_WIDTH;

    // S_FIN is the one-cycle gap that lets the final write land before RUN.
    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_FIN   = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK = 3'd5
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [c_bcw-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  chk_bad_q, chk_bad_d;
`endif

    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_word;
    logic [63:0]           w_word_ext;

    always_comb begin
        w_word = asm_q;
        for (int b = 0; b < c_bytes; b++) begin
            if (byte_cnt_q == c_bcw'(b)) begin
                w_word[b*8 +: 8] = rx_data;
            end
        end
    end

    assign w_word_ext  = 64'(w_word);
    assign w_last_byte = (byte_cnt_q == c_bcw'(c_bytes - 1));
    assign w_last_word = (({1'b0, word_idx_q} + (ADDR_WIDTH+1)'(1)) == count_q);
    assign w_accept    = rx_valid && rx_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        word_idx_d  = word_idx_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        chk_bad_d   = chk_bad_q;
`endif
        if (w_accept) begin
            asm_d      = w_word;
            byte_cnt_d = w_last_byte ? '0 : byte_cnt_q + c_bcw'(1);
        end

        case (state_q)
            S_HDR: begin
                if (w_accept && w_last_byte) begin
                    if (w_word_ext == 64'd0) begin
                        count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RUN;
`endif
                    end else if (w_word_ext > c_depth) begin
                        state_d = S_ERROR;
                    end else begin
                        count_d    = (ADDR_WIDTH+1)'(w_word);
                        word_idx_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_idx_q;
                    mem_wdata_d = w_word;
                    word_idx_d  = word_idx_q + ADDR_WIDTH'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ w_word;
                    if (w_last_word) state_d = S_CHK;
`else
                    if (w_last_word) state_d = S_FIN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept && w_last_byte) begin
                    chk_bad_d = (w_word != csum_q);
                    state_d   = S_FIN;
                end
            end
            S_FIN:   state_d = chk_bad_q ? S_ERROR : S_RUN;
`else
            S_FIN:   state_d = S_RUN;
`endif
            S_RUN, S_ERROR: begin
                if (load_req) begin
                    state_d    = S_HDR;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    word_idx_d = '0;
                    count_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    chk_bad_d  = 1'b0;
`endif
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            word_idx_q  <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            chk_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            word_idx_q  <= word_idx_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            chk_bad_q   <= chk_bad_d;
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
`else
    assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    assign cpu_reset        = (state_q != S_RUN);
    assign load_done        = (state_q == S_RUN);
    assign error            = (state_q == S_ERROR);
    assign num_instructions = (state_q == S_RUN) ? count_q : '0;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Directed, self-checking bench for imem_loader (header table plus
//             multi-cycle load, abort, reload and error-recovery sequences).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          load_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          error;
    logic [AW:0]   num_instructions;

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .load_req         (load_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .cpu_reset        (cpu_reset),
        .load_done        (load_done),
        .error            (error),
        .num_instructions (num_instructions)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            b2b   = 0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (prev_we) b2b++;
        end
        prev_we = mem_we;
    end

    typedef struct {
        logic [31:0] hdr;
        logic        err;
        logic        done;
        logic        rdy;
        logic [AW:0] num;
    } hdr_vec_t;

    hdr_vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (idx < wr_addr.size()) begin
            check({name, " addr"}, 64'(wr_addr[idx]), 64'(a));
            check({name, " data"}, 64'(wr_data[idx]), 64'(d));
        end else begin
            check({name, " count"}, 64'(wr_addr.size()), 64'(idx + 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    // Header, n data words, then the checksum trailer when the feature is built in.
    task automatic send_load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] chk);
        send_word(32'(n));
        if (n > 0) send_word(w0);
        if (n > 1) send_word(w1);
        if (n > 2) send_word(w2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(chk);
`endif
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int base;

`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 11'd0};
`else
        vecs[0] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 11'd0};
`endif
        vecs[1] = '{32'h0000_0401, 1'b1, 1'b0, 1'b0, 11'd0};
        vecs[2] = '{32'h0000_0400, 1'b0, 1'b0, 1'b1, 11'd0};
        vecs[3] = '{32'h0000_0001, 1'b0, 1'b0, 1'b1, 11'd0};
        vecs[4] = '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 11'd0};
        vecs[5] = '{32'h0001_0400, 1'b1, 1'b0, 1'b0, 11'd0};

        // Reset state
        do_reset();
        check("rst rx_ready",  64'(rx_ready),  64'd1);
        check("rst cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst mem_we",    64'(mem_we),    64'd0);
        check("rst mem_addr",  64'(mem_addr),  64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst load_done", 64'(load_done), 64'd0);
        check("rst error",     64'(error),     64'd0);
        check("rst num",       64'(num_instructions), 64'd0);

        // Header decode table: outputs one cycle after the fourth header byte
        for (int i = 0; i < 6; i++) begin
            do_reset();
            base = wr_addr.size();
            send_word(vecs[i].hdr);
            check($sformatf("hdr[%0d] error", i),     64'(error),     64'(vecs[i].err));
            check($sformatf("hdr[%0d] load_done", i), 64'(load_done), 64'(vecs[i].done));
            check($sformatf("hdr[%0d] cpu_reset", i), 64'(cpu_reset), 64'(!vecs[i].done));
            check($sformatf("hdr[%0d] rx_ready", i),  64'(rx_ready),  64'(vecs[i].rdy));
            check($sformatf("hdr[%0d] num", i),       64'(num_instructions), 64'(vecs[i].num));
            tick();
            check($sformatf("hdr[%0d] no write", i),  64'(wr_addr.size()), 64'(base));
        end

        // Three-word program
        do_reset();
        base = wr_addr.size();
        send_load(3, 32'h0000_0013, 32'h0010_0093, 32'hFFF0_0113, 32'hFFE0_0193);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("load3 chk not written", 64'(mem_we), 64'd0);
`else
        check("load3 last mem_we",    64'(mem_we),    64'd1);
        check("load3 last mem_addr",  64'(mem_addr),  64'd2);
        check("load3 last mem_wdata", 64'(mem_wdata), 64'hFFF0_0113);
`endif
        check("load3 t+1 rx_ready",  64'(rx_ready),  64'd0);
        check("load3 t+1 cpu_reset", 64'(cpu_reset), 64'd1);
        tick();
        check("load3 t+2 cpu_reset", 64'(cpu_reset), 64'd0);
        check("load3 t+2 load_done", 64'(load_done), 64'd1);
        check("load3 num",           64'(num_instructions), 64'd3);
        check("load3 write count",   64'(wr_addr.size() - base), 64'd3);
        check_wr("load3 w0", base + 0, 10'd0, 32'h0000_0013);
        check_wr("load3 w1", base + 1, 10'd1, 32'h0010_0093);
        check_wr("load3 w2", base + 2, 10'd2, 32'hFFF0_0113);

        // Bytes in RUN are ignored
        base = wr_addr.size();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
        tick();
        check("run ignore writes",    64'(wr_addr.size()), 64'(base));
        check("run ignore load_done", 64'(load_done), 64'd1);
        check("run ignore num",       64'(num_instructions), 64'd3);
        check("run ignore rx_ready",  64'(rx_ready), 64'd0);

        // Reload from RUN
        pulse_load_req();
        check("reload cpu_reset", 64'(cpu_reset), 64'd1);
        check("reload load_done", 64'(load_done), 64'd0);
        check("reload num",       64'(num_instructions), 64'd0);
        check("reload rx_ready",  64'(rx_ready), 64'd1);
        send_word(32'd1);
        check("reload mid cpu_reset", 64'(cpu_reset), 64'd1);
        send_word(32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BEEF);
`endif
        tick();
        check("reload load_done", 64'(load_done), 64'd1);
        check("reload num1",      64'(num_instructions), 64'd1);
        check_wr("reload w0", base, 10'd0, 32'hDEAD_BEEF);

        // Oversized header, then recovery with load_req
        do_reset();
        base = wr_addr.size();
        send_word(32'h0000_0401);
        check("err error",     64'(error),     64'd1);
        check("err cpu_reset", 64'(cpu_reset), 64'd1);
        check("err rx_ready",  64'(rx_ready),  64'd0);
        send_byte(8'h55);
        check("err sticky", 64'(error), 64'd1);
        pulse_load_req();
        check("err cleared",  64'(error),    64'd0);
        check("err rx_ready", 64'(rx_ready), 64'd1);
        send_load(1, 32'h0000_0033, 32'h0, 32'h0, 32'h0000_0033);
        tick();
        check("err recov load_done", 64'(load_done), 64'd1);
        check("err recov num",       64'(num_instructions), 64'd1);
        check_wr("err recov w0", base, 10'd0, 32'h0000_0033);

        // Reset coincident with the last byte of word 1 of 4 aborts that write
        do_reset();
        base = wr_addr.size();
        send_word(32'd4);
        send_word(32'h1111_1111);
        send_byte(8'h22);
        send_byte(8'h22);
        send_byte(8'h22);
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        reset    = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("abort mem_we",    64'(mem_we),    64'd0);
        check("abort rx_ready",  64'(rx_ready),  64'd1);
        check("abort cpu_reset", 64'(cpu_reset), 64'd1);
        check("abort num",       64'(num_instructions), 64'd0);
        tick();
        reset = 1'b0;
        check("abort write count", 64'(wr_addr.size() - base), 64'd1);
        base = wr_addr.size();
        send_load(2, 32'hAAAA_5555, 32'h0123_4567, 32'h0, 32'hAB89_1032);
        tick();
        check("fresh load_done", 64'(load_done), 64'd1);
        check("fresh num",       64'(num_instructions), 64'd2);
        check_wr("fresh w0", base + 0, 10'd0, 32'hAAAA_5555);
        check_wr("fresh w1", base + 1, 10'd1, 32'h0123_4567);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        base = wr_addr.size();
        send_load(2, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 32'h1D3B_5977);
        check("csum ok no write", 64'(mem_we), 64'd0);
        tick();
        check("csum ok load_done", 64'(load_done), 64'd1);
        check("csum ok error",     64'(error),     64'd0);
        check("csum ok num",       64'(num_instructions), 64'd2);
        pulse_load_req();
        send_load(2, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 32'h0000_0000);
        check("csum bad t+1 error", 64'(error), 64'd0);
        tick();
        check("csum bad error",     64'(error),     64'd1);
        check("csum bad cpu_reset", 64'(cpu_reset), 64'd1);
        check("csum bad load_done", 64'(load_done), 64'd0);
        check("csum write count",   64'(wr_addr.size() - base), 64'd4);
        check_wr("csum w0", base + 0, 10'd0, 32'h1234_5678);
        check_wr("csum w1", base + 1, 10'd1, 32'h0F0F_0F0F);
        check_wr("csum w2", base + 2, 10'd0, 32'h1234_5678);
        check_wr("csum w3", base + 3, 10'd1, 32'h0F0F_0F0F);
`endif

        check("no back-to-back mem_we", 64'(b2b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
